// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared RV32I fetch types (opcode enum, fetch FSM states,
// the canonical NOP encoding and a PC alignment helper).
package fetch_stage_pkg;

    // RV32I base opcodes as seen in instr[6:0]
    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011,
        OP_CSR   = 7'b1110011
    } rv32i_opcode;

    // FETCH: request outstanding at pc
    // DISCARD: a redirected request is still in flight and its response must be dropped
    // HOLD: a response arrived while decode was stalled and is parked locally
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HOLD    = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Word-align a target address by clearing its two low bits
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read/resp handshake between the fetch
// stage (master) and the I-cache (slave).
interface fetch_stage_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    modport master (
        output imem_address,
        output imem_read,
        input  imem_rdata,
        input  imem_resp
    );

    modport slave (
        input  imem_address,
        input  imem_read,
        output imem_rdata,
        output imem_resp
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch plus IF/ID pipeline register.
// Owns the PC, drives the I-cache read/resp handshake, absorbs decode stalls
// and EX redirects, and presents a registered instruction with pre-sliced
// opcode/funct3/funct7 fields to decode.
// Optional feature macro: FETCH_PERF_CTR_EN enables the saturating
// fetch/discard performance counters; when undefined both count ports read 0.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                if_id_valid,
    output logic [31:0]         if_id_pc,
    output logic [31:0]         if_id_instr,
    output rv32i_opcode         if_id_opcode,
    output logic [2:0]          if_id_funct3,
    output logic [6:0]          if_id_funct7,
    output logic [31:0]         fetch_count,
    output logic [31:0]         discard_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  discard_addr_q, discard_addr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic         if_id_valid_q, if_id_valid_d;
    logic [31:0]  if_id_pc_q, if_id_pc_d;
    logic [31:0]  if_id_instr_q, if_id_instr_d;

    logic         load;
    logic [31:0]  load_pc;
    logic [31:0]  load_instr;
    logic         accept;
    logic [31:0]  redirect_target;

    assign accept          = !if_id_valid_q || !stall;
    assign redirect_target = pc_align(redirect_pc);

    // Request outputs come only from state and registers so the cache never sees a loop through imem_resp
    always_comb begin
        imem.imem_read    = 1'b0;
        imem.imem_address = pc_q;
        if (!rst) begin
            imem.imem_read = (state_q != HOLD);
        end
        if (state_q == DISCARD) begin
            imem.imem_address = discard_addr_q;
        end
    end

    // Fetch FSM next state plus PC, hold entry and IF/ID next values
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        discard_addr_d = discard_addr_q;
        hold_pc_d      = hold_pc_q;
        hold_instr_d   = hold_instr_q;
        load           = 1'b0;
        load_pc        = pc_q;
        load_instr     = imem.imem_rdata;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d = redirect_target;
                    if (!imem.imem_resp) begin
                        discard_addr_d = pc_q;
                        state_d        = DISCARD;
                    end
                end else if (imem.imem_resp) begin
                    pc_d = pc_q + 32'd4;
                    if (accept) begin
                        load       = 1'b1;
                        load_pc    = pc_q;
                        load_instr = imem.imem_rdata;
                    end else begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem.imem_rdata;
                        state_d      = HOLD;
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_d = redirect_target;
                end
                if (imem.imem_resp) begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_pc    = hold_pc_q;
                    load_instr = hold_instr_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if_id_valid_d = 1'b0;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = NOP_INSTR;
        if (redirect) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
        end else if (load) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = load_pc;
            if_id_instr_d = load_instr;
        end else if (stall && if_id_valid_q) begin
            if_id_valid_d = if_id_valid_q;
            if_id_instr_d = if_id_instr_q;
        end
    end

    // State, PC, hold entry and IF/ID register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            discard_addr_q <= '0;
            hold_pc_q      <= '0;
            hold_instr_q   <= NOP_INSTR;
            if_id_valid_q  <= 1'b0;
            if_id_pc_q     <= '0;
            if_id_instr_q  <= NOP_INSTR;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            discard_addr_q <= discard_addr_d;
            hold_pc_q      <= hold_pc_d;
            hold_instr_q   <= hold_instr_d;
            if_id_valid_q  <= if_id_valid_d;
            if_id_pc_q     <= if_id_pc_d;
            if_id_instr_q  <= if_id_instr_d;
        end
    end

    assign if_id_valid  = if_id_valid_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_opcode = rv32i_opcode'(if_id_instr_q[6:0]);
    assign if_id_funct3 = if_id_instr_q[14:12];
    assign if_id_funct7 = if_id_instr_q[31:25];

`ifdef FETCH_PERF_CTR_EN
    logic        drop;
    logic [31:0] fetch_count_q;
    logic [31:0] discard_count_q;

    assign drop = ((state_q == FETCH)   && redirect && imem.imem_resp) ||
                  ((state_q == DISCARD) && imem.imem_resp) ||
                  ((state_q == HOLD)    && redirect);

    // Saturating counters of IF/ID loads and dropped responses
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q   <= '0;
            discard_count_q <= '0;
        end else begin
            if (load && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (drop && (discard_count_q != 32'hFFFF_FFFF)) begin
                discard_count_q <= discard_count_q + 32'd1;
            end
        end
    end

    assign fetch_count   = fetch_count_q;
    assign discard_count = discard_count_q;
`else
    assign fetch_count   = '0;
    assign discard_count = '0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage plus IF/ID pipeline register of the RV32I pipeline. Owns the PC and drives the instruction-memory (I-cache) port with a read/resp handshake. Absorbs decode stalls and EX-stage redirects, and presents a registered instruction with its pre-sliced opcode/funct3/funct7 fields directly to decode's `control_rom`.

## Interface
- `RESET_PC`, default 32'h0000_0060: PC value after reset.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `imem_address` out 32: fetch address, held stable while `imem_read`=1.
- `imem_read` out 1: read request, held until `imem_resp`.
- `imem_rdata` in 32: instruction word, valid when `imem_resp`=1.
- `imem_resp` in 1: one-cycle completion pulse.
- `stall` in 1: decode cannot accept; IF/ID must hold.
- `redirect` in 1: EX-resolved taken branch/jump; flush and refetch.
- `redirect_pc` in 32: redirect target.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_instr` out 32: IF/ID instruction word; NOP (32'h0000_0013) when invalid.
- `if_id_opcode` out 7 (`rv32i_opcode`): `if_id_instr[6:0]`.
- `if_id_funct3` out 3: `if_id_instr[14:12]`.
- `if_id_funct7` out 7: `if_id_instr[31:25]`.
- `fetch_count` out 32: instructions delivered to IF/ID.
- `discard_count` out 32: responses dropped due to redirect.

## Operation
- State machine `fetch_state_t` has three states: FETCH, DISCARD, HOLD.
- **FETCH**
  - Drives `imem_read`=1 and `imem_address`=pc.
  - `redirect` with `imem_resp` in the same cycle: drop the data, pc<=redirect_pc, stay in FETCH.
  - `redirect` without `imem_resp`: discard_addr<=pc, pc<=redirect_pc, go to DISCARD.
  - `imem_resp` with accept, where accept = !if_id_valid || !stall: IF/ID<={pc, rdata, valid=1}, pc<=pc+4, stay in FETCH.
  - `imem_resp` without accept: hold_pc<=pc, hold_instr<=rdata, pc<=pc+4, go to HOLD.
- **DISCARD**
  - Drives `imem_read`=1 and `imem_address`=discard_addr, so the in-flight request stays stable.
  - On `imem_resp`: drop the data and go to FETCH.
  - A further `redirect` updates pc<=redirect_pc and the state stays DISCARD; the latest redirect wins.
- **HOLD**
  - Drives `imem_read`=0.
  - `redirect`: drop the held entry, pc<=redirect_pc, go to FETCH.
  - Else `!stall`: IF/ID<={hold_pc, hold_instr, 1}, go to FETCH.
- **IF/ID update priority** (highest first):
  1. `redirect`: valid<=0, instr<=NOP.
  2. New load from FETCH or HOLD.
  3. `stall && if_id_valid`: hold contents.
  4. Otherwise: valid<=0, instr<=NOP.
- **PC arithmetic**
  - pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - `redirect_pc[1:0]` is forced to 2'b00 on load.
- `redirect` overrides `stall` in every state.

## Timing
- **Reset values** (while `rst`=1 and the cycle after):
  - pc=`RESET_PC`, state=FETCH.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=NOP.
  - Both counters 0.
  - `imem_read` is forced to 0 while `rst`=1.
- First request (`imem_read`=1, address=`RESET_PC`) appears in the first cycle after `rst` deasserts.
- IF/ID outputs are registered. `imem_resp` in cycle N gives `if_id_valid`=1 in cycle N+1.
- `imem_address`/`imem_read` depend combinationally on state and registers only, never on `imem_resp`.
- Peak throughput is one instruction per `imem_resp`. HOLD adds one bubble-free cycle before the next request.
- Reset mid-transaction abandons the outstanding request; the cache must tolerate the read dropping.

## Configuration
- `FETCH_PERF_CTR_EN` defined: `fetch_count` increments on every IF/ID load. `discard_count` increments on every dropped response: FETCH resp+redirect, DISCARD resp, and the HOLD entry dropped by redirect. Both saturate at 32'hFFFF_FFFF.
- `FETCH_PERF_CTR_EN` undefined: counter logic is absent and both ports are tied to 0.

## Structure
- `rv32i_types` additions:
  - `fetch_state_t` enum.
  - `NOP_INSTR` = 32'h0000_0013.
  - Reuse the existing `rv32i_opcode` for `if_id_opcode`.
- Single flat module; no sub-module is warranted. PC, hold entry and IF/ID register are inline.

## Test plan
- Reset release, cache resp 1 cycle after each read, no stall → fetches at 0x60, 0x64, 0x68; `if_id_valid` rises the cycle after the first resp; `fetch_count`=3 after three responses.
- Resp at 0x64 while `stall`=1 and IF/ID valid → HOLD, `imem_read`=0, IF/ID keeps 0x60. Deassert stall → IF/ID=0x64, next read at 0x68.
- `redirect`=1 to 0x200 while a read to 0x70 is pending (no resp) → DISCARD with address held at 0x70. Next resp is dropped (`discard_count`+1); the following read is at 0x200; IF/ID is invalid/NOP meanwhile.
- `redirect` to 0x300 in the same cycle as `imem_resp` → data dropped, next read at 0x300, IF/ID valid=0.
- `RESET_PC`=32'hFFFF_FFFC → second fetch address is 0x0000_0000.
- `rst` pulsed during DISCARD → `imem_read`=0 that cycle; the next cycle a fresh read at `RESET_PC`; counters cleared.
